adder_subtractor: RTL and testbench
===================================

ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result bit width (legal values 1 and above; verified at 4).
REQ-002 Port: clk  input  1  rising-edge clock; the block has one clock.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: a  input  WIDTH  operand A, unsigned.
REQ-005 Port: b  input  WIDTH  operand B, unsigned.
REQ-006 Port: c  input  1  mode select: 0 = add, 1 = subtract (A - B); also serves as carry-in of the ripple chain.
REQ-007 Port: s  output  WIDTH  registered sum/difference.
REQ-008 Port: cout  output  1  registered carry-out of the MSB stage.

Function
REQ-009 The block SHALL form b_eff = b XOR {WIDTH{c}} and compute {carry, sum} = a + b_eff + c over WIDTH+1 bits.
REQ-010 With c=0, the block SHALL produce s = (a + b) mod 2^WIDTH and cout = 1 iff a + b >= 2^WIDTH.
REQ-011 With c=1, the block SHALL produce s = (a - b) mod 2^WIDTH (two's complement) and cout = 1 iff a >= b (no borrow).
REQ-012 The block SHALL sample a, b and c on every rising clk edge, with no handshake and no valid or enable qualifier.
REQ-013 The result of inputs sampled at edge N SHALL appear on s and cout after edge N and hold until edge N+1 (latency 1 cycle, throughput 1 per cycle).
REQ-014 The outputs SHALL be driven only by flops, with no combinational path from inputs to outputs.
REQ-015 Wrap-around: addition overflow SHALL drop the MSB into cout, and a subtract underflow (a < b) SHALL wrap modulo 2^WIDTH with cout=0.
REQ-016 A change of c between cycles SHALL take effect on the very next registered result, without stalling or holding a stale value.
REQ-017 X or Z on the inputs is not supported, and the outputs are then undefined.

Reset
REQ-018 When rst=1 at a rising edge, s SHALL be 0 and cout SHALL be 0 after that edge, regardless of a, b and c.
REQ-019 Reset SHALL take priority over computation, and a reset asserted mid-stream SHALL discard the in-flight result.
REQ-020 The first valid result after reset deasserts SHALL appear one edge after the first edge sampled with rst=0.
REQ-021 The block SHALL hold no state other than the s and cout registers.

Structure
REQ-022 A shared package SHALL hold the default width constant (4) and the mode encodings ADD=0, SUB=1.
REQ-023 The datapath SHALL be a ripple-carry chain of WIDTH instances of one sub-module, full_adder (ports a, b, cin, sum, cout), whose bit 0 cin is tied to c.
REQ-024 The XOR inversion of b, the ripple chain and the output register stage SHALL live in adder_subtractor.

Verification
REQ-025 Reset: with a=5, b=3 and c=1, assert rst for 2 cycles -> s=0000 and cout=0; release rst -> one cycle later s=0010 and cout=1.
REQ-026 Subtract with no borrow and with borrow: c=1, a=0011, b=0101 -> s=1110, cout=0; then c=1, a=b=0000 -> s=0000, cout=1.
REQ-027 Add with carry: c=0, a=1111, b=0001 -> s=0000, cout=1; then c=0, a=0110, b=0111 -> s=1101, cout=0.
REQ-028 Exhaustive sweep: c=1 with all 16x16 (a,b) pairs, one per cycle -> each result matches (a-b) mod 16 with cout=(a>=b), one cycle late.
REQ-029 Mode toggle and mid-stream reset: alternate c each cycle with a=9, b=4 -> outputs alternate 1101/cout=0 and 0101/cout=1; then rst=1 for one cycle -> outputs 0 for exactly that cycle.

Source files
------------

// File: rtl/adder_subtractor_pkg.sv
// Shared constants for the adder/subtractor slice: default datapath width
// and the encoding of the add/subtract mode select.
package adder_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } modeE;

endpackage : adder_subtractor_pkg

// File: rtl/adder_subtractor_full_adder.sv
// Single-bit full adder; one stage of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic halfSum;

    assign halfSum = a ^ b;
    assign sum     = halfSum ^ cin;
    assign cout    = (a & b) | (cin & halfSum);

endmodule : full_adder

// File: rtl/adder_subtractor.sv
// Registered ripple-carry adder/subtractor: c selects subtract and doubles
// as the carry-in, so A - B is formed as A + ~B + 1.
module adder_subtractor
    import adder_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] bEff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    assign bEff     = b ^ {WIDTH{c}};
    assign carry[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : gRipple
        full_adder uStage (
            .a    (a[i]),
            .b    (bEff[i]),
            .cin  (carry[i]),
            .sum  (s_d[i]),
            .cout (carry[i+1])
        );
    end

    assign cout_d = carry[WIDTH];

    // Reset wins over any in-flight result; otherwise capture every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule : adder_subtractor

// File: tb/tb_adder_subtractor.sv
// Scoreboard bench for adder_subtractor: the driver queues expected results
// from an arithmetic model, and a monitor checks them one cycle later.
module tb_adder_subtractor;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        string            name;
    } expT;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] s;
    logic             cout;

    expT expQ[$];
    int  checks;
    int  errors;

    adder_subtractor #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .c    (c),
        .s    (s),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned operands.
    function automatic expT model(input logic r, input int av, input int bv,
                                  input logic cv, input string name);
        expT e;
        int  res;
        e.name = name;
        if (r) begin
            e.s    = '0;
            e.cout = 1'b0;
        end else if (cv == 1'b0) begin
            res    = av + bv;
            e.s    = WIDTH'(res % MOD);
            e.cout = (res >= MOD);
        end else begin
            res    = (av - bv + MOD) % MOD;
            e.s    = WIDTH'(res);
            e.cout = (av >= bv);
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input int av, input int bv,
                                 input logic cv, input string name);
        @(negedge clk);
        rst = r;
        a   = WIDTH'(av);
        b   = WIDTH'(bv);
        c   = cv;
        expQ.push_back(model(r, av, bv, cv, name));
    endtask

    task automatic checkOutput(input expT e);
        checks++;
        if (s !== e.s || cout !== e.cout) begin
            errors++;
            $display("[TB] FAIL %s: got s=%b cout=%b, expected s=%b cout=%b",
                     e.name, s, cout, e.s, e.cout);
        end
    endtask

    // Monitor: each popped entry belongs to the edge just taken.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        c   = 1'b0;

        applyStimulus(1'b1, 5, 3, 1'b1, "reset_hold0");
        applyStimulus(1'b1, 5, 3, 1'b1, "reset_hold1");
        applyStimulus(1'b0, 5, 3, 1'b1, "reset_release");

        applyStimulus(1'b0, 3, 5, 1'b1, "sub_borrow");
        applyStimulus(1'b0, 0, 0, 1'b1, "sub_zero");
        applyStimulus(1'b0, 15, 1, 1'b0, "add_carry");
        applyStimulus(1'b0, 6, 7, 1'b0, "add_nocarry");

        for (int ai = 0; ai < MOD; ai++)
            for (int bi = 0; bi < MOD; bi++)
                applyStimulus(1'b0, ai, bi, 1'b1, "sub_sweep");

        for (int k = 0; k < 8; k++)
            applyStimulus(1'b0, 9, 4, logic'(k % 2), "mode_toggle");
        applyStimulus(1'b1, 9, 4, 1'b1, "midstream_reset");
        applyStimulus(1'b0, 9, 4, 1'b1, "after_reset_sub");
        applyStimulus(1'b0, 9, 4, 1'b0, "after_reset_add");

        for (int k = 0; k < 200; k++)
            applyStimulus(logic'($urandom_range(0, 15) == 0),
                          int'($urandom_range(0, MOD - 1)),
                          int'($urandom_range(0, MOD - 1)),
                          logic'($urandom_range(0, 1)), "random");

        @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0",
                     expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_adder_subtractor
